// File: rtl/rv32_pkg.sv
// Shared types for the RV32I core memory path: widths, arbiter states and the
// memory request bundle.
package rv32_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IF,
    WAIT_LS
  } arb_state_e;

  typedef enum logic {
    SEL_IF,
    SEL_LS
  } arb_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            we;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// Saturating count of LSU grants taken while a fetch was waiting; at_max_o
// tells the arbiter to let the IFU win the next arbitration.
module arb_starve_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);

  localparam logic [3:0] CNT_MAX = 4'(MAX);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_max_o = (count_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store:
// LSU-first priority, IFU starvation guard, one transaction in flight.
//
// state   | meaning
// IDLE    | arbitrate and present the winner to memory
// WAIT_IF | fetch accepted by memory, waiting for its response
// WAIT_LS | load/store accepted by memory, waiting for its response
module mem_port_arbiter
  import rv32_pkg::*;
#(
  parameter int          XLEN       = rv32_pkg::XLEN,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_rsp_valid,
  output logic [XLEN-1:0] if_rsp_rdata,

  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic [XLEN-1:0] ls_addr,
  input  logic            ls_we,
  input  logic [3:0]      ls_be,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_rsp_valid,
  output logic [XLEN-1:0] ls_rsp_rdata,

  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata
);

  // Assertion follows rst_n immediately; release is retimed to clk.
  logic rst_meta_q, rst_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  arb_state_e state_q, state_d;
  arb_sel_e   lock_sel_q, lock_sel_d;
  logic       lock_q, lock_d;
  logic       drop_q, drop_d;

  arb_sel_e   arb_sel, sel;
  mem_req_t   if_req, ls_req, mux_req;
  logic       in_idle, lock_hold, if_hs, ls_hs;
  logic       at_max, cnt_clr, cnt_inc;

  always_comb begin
    if_req.addr  = if_addr;
    if_req.we    = 1'b0;
    if_req.be    = 4'hF;
    if_req.wdata = '0;
    ls_req.addr  = ls_addr;
    ls_req.we    = ls_we;
    ls_req.be    = ls_be;
    ls_req.wdata = ls_wdata;

    arb_sel = (ls_req_valid && !(if_req_valid && at_max)) ? SEL_LS : SEL_IF;
    // A flushed fetch must not keep the port pinned while memory stalls.
    lock_hold = lock_q && !(if_flush && (lock_sel_q == SEL_IF));
    sel       = lock_hold ? lock_sel_q : arb_sel;
    mux_req   = (sel == SEL_LS) ? ls_req : if_req;

    in_idle       = rst_sync_q && (state_q == IDLE);
    mem_req_valid = in_idle && (if_req_valid || ls_req_valid);
    if_hs         = in_idle && mem_req_ready && (sel == SEL_IF) && if_req_valid;
    ls_hs         = in_idle && mem_req_ready && (sel == SEL_LS) && ls_req_valid;
  end

  assign if_req_ready = if_hs;
  assign ls_req_ready = ls_hs;
  assign mem_addr     = mux_req.addr;
  assign mem_we       = mux_req.we;
  assign mem_be       = mux_req.be;
  assign mem_wdata    = mux_req.wdata;

  assign if_rsp_valid = rst_sync_q && (state_q == WAIT_IF) && mem_rsp_valid
                        && !drop_q && !if_flush;
  assign ls_rsp_valid = rst_sync_q && (state_q == WAIT_LS) && mem_rsp_valid;
  assign if_rsp_rdata = mem_rsp_rdata;
  assign ls_rsp_rdata = mem_rsp_rdata;

  always_comb begin
    state_d    = state_q;
    lock_d     = 1'b0;
    lock_sel_d = lock_sel_q;
    drop_d     = drop_q;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (mem_req_valid && !mem_req_ready) begin
          lock_d     = 1'b1;
          lock_sel_d = sel;
        end
        if (if_hs) begin
          state_d = WAIT_IF;
          drop_d  = if_flush;
        end else if (ls_hs) begin
          state_d = WAIT_LS;
        end
      end
      WAIT_IF: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else if (if_flush) begin
          drop_d = 1'b1;
        end
      end
      WAIT_LS: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q    <= IDLE;
      lock_q     <= 1'b0;
      lock_sel_q <= SEL_IF;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      drop_q     <= drop_d;
    end
  end

  assign cnt_clr = in_idle && (if_hs || !if_req_valid);
  assign cnt_inc = ls_hs && if_req_valid;

  arb_starve_counter #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst_n   (rst_sync_q),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .at_max_o(at_max)
  );

  a_no_rsp_in_idle: assert property (@(posedge clk) disable iff (!rst_sync_q)
    !((state_q == IDLE) && mem_rsp_valid));

endmodule
